// File: rtl/fifo_push_arb_if.sv
// Push-side bundle between the producers, the arbiter and the shared fifo.
// The master modport is the arbiter's view. The slave modport is the producer/fifo side.
interface fifo_push_arb_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int PTR_W  = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    fifo_full;
  logic [PTR_W:0]          fifo_level;
  logic                    fifo_push;
  logic [DATA_W-1:0]       fifo_data_in;
  logic [ID_W-1:0]         fifo_src_id;
  logic                    grant_valid;
  logic [ID_W-1:0]         grant_id;
  logic [PTR_W:0]          hiwater;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_level,
    output req_ready, fifo_push, fifo_data_in, fifo_src_id,
           grant_valid, grant_id, hiwater
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_level,
    input  req_ready, fifo_push, fifo_data_in, fifo_src_id,
           grant_valid, grant_id, hiwater
  );
endinterface

// File: rtl/fifo_push_arb.sv
// Round-robin burst arbiter that shares one fifo push port among N_REQ producers.
// Each pushed beat is tagged with the ID of its source.
module fifo_push_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int PTR_W     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  fifo_push_arb_if.master  bus
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0] LAST_REQ  = ID_W'(N_REQ - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   grant_id_reg, grant_id_next;
  logic [ID_W-1:0]   last_id_reg, last_id_next;
  logic              grant_valid_reg, grant_valid_next;
  logic [BC_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [PTR_W:0]    hiwater_reg;

  logic [DATA_W-1:0] data_arr [N_REQ];
  logic [N_REQ-1:0]  ready_vec;
  logic [ID_W-1:0]   winner;
  logic              found;
  int                idx;
  logic              grant_ready, owner_valid, transfer;

  // Ready is gated by rst so that nothing is accepted while reset is held.
  assign grant_ready = !rst && (state_reg == BURST) && !bus.fifo_full;
  assign owner_valid = bus.req_valid[grant_id_reg];
  assign transfer    = grant_ready && owner_valid;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign data_arr[gi]  = bus.req_data[gi*DATA_W +: DATA_W];
    assign ready_vec[gi] = grant_ready && (grant_id_reg == ID_W'(gi));
  end

  assign bus.req_ready    = ready_vec;
  assign bus.fifo_push    = transfer;
  assign bus.fifo_data_in = data_arr[grant_id_reg];
  assign bus.fifo_src_id  = grant_id_reg;
  assign bus.grant_valid  = grant_valid_reg;
  assign bus.grant_id     = grant_id_reg;
  assign bus.hiwater      = hiwater_reg;

  // Cyclic search beginning just after the most recent owner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(last_id_reg) + 1 + k) % N_REQ;
      if (!found && bus.req_valid[ID_W'(idx)]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_id_next    = grant_id_reg;
    grant_valid_next = grant_valid_reg;
    beat_cnt_next    = beat_cnt_reg;
    last_id_next     = last_id_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next       = BURST;
          grant_id_next    = winner;
          grant_valid_next = 1'b1;
          beat_cnt_next    = '0;
        end
      end
      BURST: begin
        // A dropped valid releases ownership. A full fifo only stalls the burst.
        if (!owner_valid) begin
          state_next       = IDLE;
          grant_valid_next = 1'b0;
          last_id_next     = grant_id_reg;
        end else if (transfer) begin
          if (beat_cnt_reg == LAST_BEAT) begin
            state_next       = IDLE;
            grant_valid_next = 1'b0;
            last_id_next     = grant_id_reg;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      grant_id_reg    <= '0;
      grant_valid_reg <= 1'b0;
      beat_cnt_reg    <= '0;
      last_id_reg     <= LAST_REQ;
      hiwater_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      grant_id_reg    <= grant_id_next;
      grant_valid_reg <= grant_valid_next;
      beat_cnt_reg    <= beat_cnt_next;
      last_id_reg     <= last_id_next;
      if (bus.fifo_level > hiwater_reg)
        hiwater_reg <= bus.fifo_level;
    end
  end
endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed bench for fifo_push_arb: simple producer and fifo models, a push log,
// and hand-computed expectations for each scenario.
module tb_fifo_push_arb;
  localparam int N_REQ = 4, DATA_W = 8, PTR_W = 4, MAX_BURST = 4, DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_push_arb_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

  fifo_push_arb #(.N_REQ(N_REQ), .DATA_W(DATA_W), .PTR_W(PTR_W), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_pass = 0, n_total = 0;
  int          rem [N_REQ];
  logic [7:0]  nxt [N_REQ];
  int          level;
  bit          force_full, drain, pop_req, rst_v;
  int          onehot_err, overflow_err;
  int          got_data[$], got_src[$], exp_data[$], exp_src[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive();
    rst = rst_v;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_valid[i] = (rem[i] > 0);
      bus.req_data[i*DATA_W +: DATA_W] = nxt[i];
    end
    bus.fifo_level = (PTR_W+1)'(level);
    bus.fifo_full  = (level >= DEPTH) || force_full;
  endtask

  // Finish the current cycle; return at posedge+2 of the next cycle with inputs driven.
  task automatic cycle();
    logic [N_REQ-1:0] xfer;
    bit pushed;
    @(negedge clk);
    if ($countones(bus.req_ready) > 1) onehot_err++;
    if (bus.fifo_push && bus.fifo_full) overflow_err++;
    xfer   = bus.req_valid & bus.req_ready;
    pushed = bus.fifo_push;
    if (pushed) begin
      got_data.push_back(int'(bus.fifo_data_in));
      got_src.push_back(int'(bus.fifo_src_id));
      $display("push src=%0d data=0x%02h level=%0d t=%0t",
               bus.fifo_src_id, bus.fifo_data_in, level, $time);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++)
      if (xfer[i]) begin
        rem[i]--;
        nxt[i]++;
      end
    if (drain) level = 0;
    else level = level + (pushed ? 1 : 0) - (pop_req ? 1 : 0);
    pop_req = 1'b0;
    drive();
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    for (int i = 0; i < N_REQ; i++) rem[i] = 0;
    force_full = 1'b0;
    drain      = 1'b0;
    pop_req    = 1'b0;
    level      = 0;
    cycle();
    cycle();
    check("rst_grant_valid", bus.grant_valid, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_push", bus.fifo_push, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_hiwater", bus.hiwater, 0);
    rst_v = 1'b0;
    got_data.delete();
    got_src.delete();
    exp_data.delete();
    exp_src.delete();
  endtask

  task automatic expect_beats(input int src, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_src.push_back(src);
      exp_data.push_back((base + i) & 8'hff);
    end
  endtask

  task automatic check_log(input string tag);
    check($sformatf("%s_count", tag), got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      check($sformatf("%s_src%0d", tag, i), got_src[i], exp_src[i]);
      check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      rem[i] = 0;
      nxt[i] = 8'h00;
    end
    level = 0; force_full = 0; drain = 0; pop_req = 0; rst_v = 1'b1;
    onehot_err = 0; overflow_err = 0;
    drive();

    // Single requester, 6 beats: 4-beat burst, IDLE gap, 2-beat burst.
    do_reset();
    rem[0] = 6; nxt[0] = 8'h10;
    cycle();
    check("t1_c0_ready", bus.req_ready, 0);
    check("t1_c0_push", bus.fifo_push, 0);
    cycle();
    check("t1_c1_grant_valid", bus.grant_valid, 1);
    check("t1_c1_grant_id", bus.grant_id, 0);
    check("t1_c1_ready", bus.req_ready, 4'b0001);
    check("t1_c1_data", bus.fifo_data_in, 8'h10);
    run(4);
    check("t1_gap_push", bus.fifo_push, 0);
    check("t1_gap_grant_valid", bus.grant_valid, 0);
    cycle();
    check("t1_regrant_data", bus.fifo_data_in, 8'h14);
    run(5);
    expect_beats(0, 8'h10, 6);
    check_log("t1");

    // All four continuously valid: 0,1,2,3,0,1,2,3 in 4-beat bursts.
    do_reset();
    drain = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      rem[i] = 8;
      nxt[i] = 8'(8'h20 + 8'h10 * i);
    end
    onehot_err = 0;
    run(46);
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N_REQ; s++)
        expect_beats(s, 8'h20 + 8'h10 * s + 4 * r, 4);
    check_log("t2");
    check("t2_onehot_errs", onehot_err, 0);

    // Requester 2 stalled by fifo_full for 5 cycles after beat 2.
    do_reset();
    rem[2] = 4; nxt[2] = 8'h60;
    run(3);
    check("t3_beat2_data", bus.fifo_data_in, 8'h61);
    force_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("t3_stall%0d_push", k), bus.fifo_push, 0);
      check($sformatf("t3_stall%0d_ready", k), bus.req_ready, 0);
      check($sformatf("t3_stall%0d_gid", k), bus.grant_id, 2);
    end
    force_full = 1'b0;
    cycle();
    check("t3_resume_push", bus.fifo_push, 1);
    check("t3_resume_data", bus.fifo_data_in, 8'h62);
    run(2);
    check("t3_release", bus.grant_valid, 0);
    expect_beats(2, 8'h60, 4);
    check_log("t3");

    // Requester 1 drops valid after 1 beat; requester 3 follows, then 0.
    do_reset();
    rem[1] = 1; nxt[1] = 8'h70;
    rem[3] = 4; nxt[3] = 8'h80;
    run(2);
    check("t4_c1_gid", bus.grant_id, 1);
    check("t4_c1_push", bus.fifo_push, 1);
    rem[0] = 2; nxt[0] = 8'h90;
    cycle();
    check("t4_drop_push", bus.fifo_push, 0);
    cycle();
    check("t4_idle_grant_valid", bus.grant_valid, 0);
    cycle();
    check("t4_next_gid", bus.grant_id, 3);
    check("t4_next_data", bus.fifo_data_in, 8'h80);
    run(10);
    expect_beats(1, 8'h70, 1);
    expect_beats(3, 8'h80, 4);
    expect_beats(0, 8'h90, 2);
    check_log("t4");

    // Reset pulse during beat 2 of requester 3; requester 0 wins afterwards.
    do_reset();
    rem[3] = 4; nxt[3] = 8'hA0;
    run(3);
    check("t5_beat2_data", bus.fifo_data_in, 8'hA1);
    rst_v = 1'b1;
    rem[0] = 2; nxt[0] = 8'hB0;
    cycle();
    check("t5_inrst_push", bus.fifo_push, 0);
    rst_v = 1'b0;
    cycle();
    check("t5_after_grant_valid", bus.grant_valid, 0);
    check("t5_after_push", bus.fifo_push, 0);
    cycle();
    check("t5_first_gid", bus.grant_id, 0);
    check("t5_first_data", bus.fifo_data_in, 8'hB0);
    run(10);
    expect_beats(3, 8'hA0, 2);
    expect_beats(0, 8'hB0, 2);
    expect_beats(3, 8'hA2, 2);
    check_log("t5");

    // Fill the fifo to 16 with no pops, then a single pop.
    do_reset();
    rem[1] = 20; nxt[1] = 8'h00;
    for (int k = 0; k < 60 && level < DEPTH; k++) cycle();
    check("t6_fill_reached", level, DEPTH);
    check("t6_full_push", bus.fifo_push, 0);
    cycle();
    check("t6_full_grant_valid", bus.grant_valid, 1);
    check("t6_full_ready", bus.req_ready, 0);
    check("t6_full_push2", bus.fifo_push, 0);
    check("t6_hiwater", bus.hiwater, 16);
    pop_req = 1'b1;
    cycle();
    check("t6_pop_push", bus.fifo_push, 1);
    check("t6_pop_data", bus.fifo_data_in, 8'h10);
    check("t6_pop_src", bus.fifo_src_id, 1);
    check("t6_pop_hiwater", bus.hiwater, 16);
    cycle();
    check("t6_refull_push", bus.fifo_push, 0);
    check("t6_refull_hiwater", bus.hiwater, 16);
    check("overflow_errs", overflow_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
